bf_dp_exec: RTL and testbench

//  Data-pointer/cell execute stage for the bfX core; sits upstream of addersub_16 and owns its operands.

---
 rtl/bf_dp_exec_pkg.sv | 26 ++
 rtl/addersub_16.sv | 12 +
 rtl/bf_dp_exec.sv | 154 +++++++++++++++
 tb/tb_bf_dp_exec.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_dp_exec_pkg.sv
// Shared opcode and FSM state types for the bfX data-pointer execute stage.
// Imported by bf_dp_exec; opcode values match the op_code port encoding.
package bf_dp_exec_pkg;

    localparam int unsigned ALU_W = 16;

    typedef enum logic [1:0] {
        OP_INC   = 2'd0,
        OP_DEC   = 2'd1,
        OP_RIGHT = 2'd2,
        OP_LEFT  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RDW,
        ST_WR,
        ST_MOV
    } state_e;

    function automatic logic is_cell_op(input op_e op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/addersub_16.sv
// 16-bit adder/subtractor shared by the cell and pointer datapaths.
// sub=0: sum=a+b, sub=1: sum=a-b, both modulo 2^16.
module addersub_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum
);

    assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/bf_dp_exec.sv
// Data-pointer / cell execute stage: folded + - > < ops, one-entry write-through cell cache.
// Optional BF_DP_PTR_TRAP_EN: out-of-range moves hold ptr and set sticky err instead of wrapping.
module bf_dp_exec
    import bf_dp_exec_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CELL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [15:0]       op_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [CELL_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [CELL_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] ptr,
    output logic              cell_zero,
    output logic              cell_valid,
    output logic              err
);

    state_e             state, state_nxt;
    op_e                op_q;
    logic [15:0]        cnt_q;
    logic [ADDR_W-1:0]  ptr_q;
    logic [CELL_W-1:0]  cell_q;
    logic               cell_valid_q;
    logic               accept;
    logic               trap;

    logic [ALU_W-1:0]   add_a;
    logic [ALU_W-1:0]   add_b;
    logic               add_sub;
    logic [ALU_W-1:0]   add_sum;

    assign accept = op_valid && (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (op_valid) begin
                    if (is_cell_op(op_e'(op_code))) begin
                        state_nxt = cell_valid_q ? ST_WR : ST_RD;
                    end else begin
                        state_nxt = ST_MOV;
                    end
                end
            end
            ST_RD:   state_nxt = ST_RDW;
            ST_RDW:  state_nxt = ST_WR;
            ST_WR:   state_nxt = ST_IDLE;
            ST_MOV:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // One adder serves both paths: the pointer in MOV, the cached cell otherwise.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        if (state == ST_MOV) begin
            add_a   = ALU_W'(ptr_q);
            add_b   = cnt_q;
            add_sub = (op_q == OP_LEFT);
        end else begin
            add_a   = ALU_W'(cell_q);
            add_b   = ALU_W'(cnt_q[CELL_W-1:0]);
            add_sub = (op_q == OP_DEC);
        end
    end

    addersub_16 u_addsub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .sum (add_sum)
    );

`ifdef BF_DP_PTR_TRAP_EN
    logic [ADDR_W-1:0] headroom;
    logic              err_q;

    // Exact-range check done on the operands, so no wider adder is needed.
    assign headroom = {ADDR_W{1'b1}} - ptr_q;
    assign trap     = (op_q == OP_LEFT) ? (cnt_q > ALU_W'(ptr_q))
                                        : (cnt_q > ALU_W'(headroom));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state == ST_MOV) && trap) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign trap = 1'b0;
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= OP_INC;
            cnt_q        <= '0;
            ptr_q        <= '0;
            cell_q       <= '0;
            cell_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= op_e'(op_code);
                cnt_q <= op_count;
            end
            case (state)
                ST_RDW: cell_q <= mem_rdata;
                ST_WR: begin
                    cell_q       <= add_sum[CELL_W-1:0];
                    cell_valid_q <= 1'b1;
                end
                ST_MOV: begin
                    if (!trap) begin
                        ptr_q        <= add_sum[ADDR_W-1:0];
                        cell_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign op_ready   = (state == ST_IDLE);
    assign mem_re     = (state == ST_RD);
    assign mem_we     = (state == ST_WR);
    assign mem_wdata  = add_sum[CELL_W-1:0];
    assign mem_addr   = ptr_q;
    assign ptr        = ptr_q;
    assign cell_valid = cell_valid_q;
    assign cell_zero  = cell_valid_q && (cell_q == '0);

endmodule

// File: tb/tb_bf_dp_exec.sv
// Scoreboard bench for bf_dp_exec (ADDR_W=16, CELL_W=8): expected writes queued at issue,
// popped by a monitor on every mem_we; trap expectations follow BF_DP_PTR_TRAP_EN.
module tb_bf_dp_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_code;
    logic [15:0] op_count;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [15:0] ptr;
    logic        cell_zero;
    logic        cell_valid;
    logic        err;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int unsigned cyc;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    int unsigned re_cnt = 0;
    int unsigned acc;
    logic [7:0]  mem [0:65535];

    bf_dp_exec #(.ADDR_W(16), .CELL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_count   (op_count),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .ptr        (ptr),
        .cell_zero  (cell_zero),
        .cell_valid (cell_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_re) re_cnt++;
            if (mem_re && mem_we) begin
                checks++;
                errors++;
                $display("FAIL re_we_overlap: got re=1 we=1 expected not both");
            end
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                             mem_addr, mem_wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                    chk("wr_data", 32'(mem_wdata), 32'(e.data));
                    chk("wr_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at #1 after an edge; returns with acc = cycle right after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [15:0] cnt);
        int unsigned n;
        n = 0;
        op_code  = op;
        op_count = cnt;
        op_valid = 1'b1;
        while (!op_ready && n < 50) begin
            step(1);
            n++;
        end
        if (!op_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got op_ready=0 expected 1 within 50 cycles");
        end
        step(1);
        op_valid = 1'b0;
        acc      = cyc;
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (!op_ready && n < 20) begin
            step(1);
            n++;
        end
        chk("idle_timeout", 32'(op_ready), 32'd1);
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [7:0] d, input int unsigned c);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    initial begin
        int unsigned re_before;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[0]    = 8'h10;
        mem_rdata = 8'h00;
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        op_code   = 2'd0;
        op_count  = 16'd0;
        step(2);
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_ptr", 32'(ptr), 32'd0);
        chk("rst_cell_valid", 32'(cell_valid), 32'd0);
        chk("rst_cell_zero", 32'(cell_zero), 32'd0);
        chk("rst_re_we", 32'({mem_re, mem_we}), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step(1);

        // 1: miss path, INC 3 on mem[0]=0x10
        issue(2'd0, 16'd3);
        expect_wr(16'h0000, 8'h13, acc + 2);
        chk("t1_re", 32'(mem_re), 32'd1);
        chk("t1_re_addr", 32'(mem_addr), 32'd0);
        chk("t1_busy", 32'(op_ready), 32'd0);
        step(2);
        chk("t1_busy_wr", 32'(op_ready), 32'd0);
        step(1);
        chk("t1_ready", 32'(op_ready), 32'd1);
        chk("t1_cell_valid", 32'(cell_valid), 32'd1);

        // 2: cache hit, no read
        re_before = re_cnt;
        issue(2'd0, 16'd1);
        expect_wr(16'h0000, 8'h14, acc);
        chk("t2_no_re", 32'(mem_re), 32'd0);
        step(1);
        chk("t2_ready", 32'(op_ready), 32'd1);
        chk("t2_re_count", re_cnt - re_before, 32'd0);

        // 3: wrap and cell_zero at ptr 1
        issue(2'd2, 16'd1);
        wait_idle();
        chk("t3_ptr", 32'(ptr), 32'd1);
        chk("t3_cv_clear", 32'(cell_valid), 32'd0);
        issue(2'd1, 16'd1);
        expect_wr(16'h0001, 8'hFF, acc + 2);
        wait_idle();
        chk("t3_dec_zero", 32'(cell_zero), 32'd0);
        issue(2'd0, 16'd1);
        expect_wr(16'h0001, 8'h00, acc);
        wait_idle();
        chk("t3_inc_zero", 32'(cell_zero), 32'd1);
        issue(2'd0, 16'd0);
        expect_wr(16'h0001, 8'h00, acc);
        wait_idle();
        issue(2'd0, 16'h0102);
        expect_wr(16'h0001, 8'h02, acc);
        wait_idle();
        chk("t3_hibits_zero", 32'(cell_zero), 32'd0);
        issue(2'd2, 16'd0);
        wait_idle();
        chk("t3_mov0_ptr", 32'(ptr), 32'd1);
        chk("t3_mov0_cv", 32'(cell_valid), 32'd0);

        // 4: RIGHT 5 from 0xFFFE with a valid cached cell
        issue(2'd2, 16'hFFFD);
        wait_idle();
        chk("t4_pos", 32'(ptr), 32'hFFFE);
        issue(2'd0, 16'd0);
        expect_wr(16'hFFFE, 8'h00, acc + 2);
        wait_idle();
        chk("t4_cv_set", 32'(cell_valid), 32'd1);
        issue(2'd2, 16'd5);
        step(1);
        chk("t4_ready_t2", 32'(op_ready), 32'd1);
`ifdef BF_DP_PTR_TRAP_EN
        chk("t4_ptr", 32'(ptr), 32'hFFFE);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_cv", 32'(cell_valid), 32'd1);
        issue(2'd3, 16'hFFFD);
`else
        chk("t4_ptr", 32'(ptr), 32'h0003);
        chk("t4_err", 32'(err), 32'd0);
        chk("t4_cv", 32'(cell_valid), 32'd0);
        issue(2'd3, 16'd2);
`endif
        wait_idle();
        chk("t5_pos", 32'(ptr), 32'd1);

        // 5: LEFT 2 from ptr 1
        issue(2'd3, 16'd2);
        wait_idle();
`ifdef BF_DP_PTR_TRAP_EN
        chk("t5_ptr", 32'(ptr), 32'h0001);
        chk("t5_err", 32'(err), 32'd1);
`else
        chk("t5_ptr", 32'(ptr), 32'hFFFF);
        chk("t5_err", 32'(err), 32'd0);
`endif

        // 6: reset during RDW abandons the RMW
        issue(2'd0, 16'd1);
        chk("t6_rd", 32'(mem_re), 32'd1);
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_re_we", 32'({mem_re, mem_we}), 32'd0);
        chk("t6_ptr", 32'(ptr), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("t6_ready", 32'(op_ready), 32'd1);
        chk("t6_cv", 32'(cell_valid), 32'd0);
        step(3);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
